pipeline_ctrl: RTL and testbench

Central hazard and exception controller for the 5-stage MIPS32 pipeline. It produces the `stall[5:0]` vector and `flush` pulse consumed by every inter-stage register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It also supplies the exception/ERET redirect PC to the PC register, and sequences the EX-stage multi-cycle divider so that a divide instruction holds EX until its result is ready.

---
 rtl/pipeline_ctrl_if.sv | 32 +++
 rtl/pipeline_ctrl.sv | 105 ++++++++++
 tb/tb_pipeline_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the hazard/exception controller and the datapath
// stages, CP0 and the EX-stage divider. The controller side is the master.
interface pipeline_ctrl_if;
  logic        stallreq_if_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;
  logic        div_req_i;
  logic        div_ready_i;
  logic [31:0] exception_type_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        div_start_o;
  logic        div_annul_o;
  logic [31:0] stall_cycles_o;

  modport master (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  div_req_i, div_ready_i, exception_type_i, cp0_epc_i,
    output stall_o, flush_o, new_pc_o, div_start_o, div_annul_o,
    output stall_cycles_o
  );

  modport slave (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output div_req_i, div_ready_i, exception_type_i, cp0_epc_i,
    input  stall_o, flush_o, new_pc_o, div_start_o, div_annul_o,
    input  stall_cycles_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central hazard/exception controller for the 5-stage MIPS32 pipeline.
// Generates the stall vector and flush pulse, the exception/ERET redirect
// PC, sequences the EX-stage multi-cycle divider and counts stall cycles.
//
// Divider FSM:
//   state    | meaning
//   DIV_IDLE | no divide in flight; a div_req launches the divider
//   DIV_BUSY | divider running, EX held until div_ready
//   DIV_DONE | one-cycle release window, EX captures the result
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.master bus
);

  localparam logic [31:0] EXC_ERET = 32'h0000_000e;
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  div_state_e  div_state_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  logic        flush;
  logic        div_idle;
  logic        div_busy;
  logic        ex_req;
  logic [5:0]  stall_raw;
  logic [5:0]  stall;

  assign div_idle = (div_state_q == DIV_IDLE);
  assign div_busy = (div_state_q == DIV_BUSY);

  // An exception reaching MEM squashes everything younger this edge.
  assign flush = (bus.exception_type_i != 32'd0);

  // A divide holds EX from the cycle it is requested until its result lands;
  // the DONE window deliberately releases EX so the divide is not relaunched.
  assign ex_req = bus.stallreq_ex_i | (div_idle & bus.div_req_i) | div_busy;

  // Deepest requesting stage decides how much of the front end is frozen.
  always_comb begin
    stall_raw = 6'b000000;
    if (bus.stallreq_mem_i)      stall_raw = 6'b011111;
    else if (ex_req)             stall_raw = 6'b001111;
    else if (bus.stallreq_id_i)  stall_raw = 6'b000111;
    else if (bus.stallreq_if_i)  stall_raw = 6'b000011;
  end

  assign stall = flush ? 6'b000000 : stall_raw;

  // Redirect target, only meaningful while flushing.
  always_comb begin
    bus.new_pc_o = 32'd0;
    if (flush) begin
      if (bus.exception_type_i == EXC_ERET) bus.new_pc_o = bus.cp0_epc_i;
      else                                  bus.new_pc_o = EXC_VECTOR;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.flush_o     = flush;
  assign bus.div_start_o = div_idle & bus.div_req_i & ~flush;
  // Reset clears the divider directly, so no annul is needed then.
  assign bus.div_annul_o = div_busy & flush & ~rst;

  // Saturating count of cycles that hold any part of the pipe.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall != 6'b000000) && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Divider sequencing: flush abandons any divide in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_state_q <= DIV_IDLE;
    end else if (flush) begin
      div_state_q <= DIV_IDLE;
    end else begin
      unique case (div_state_q)
        DIV_IDLE: if (bus.div_req_i)   div_state_q <= DIV_BUSY;
        DIV_BUSY: if (bus.div_ready_i) div_state_q <= DIV_DONE;
        DIV_DONE:                      div_state_q <= DIV_IDLE;
        default:                       div_state_q <= DIV_IDLE;
      endcase
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= 32'd0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.EXC_VECTOR(32'h0000_0040)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: a divide is either "outstanding" (launched, result not
  // back yet) or "handing off" (result came back last cycle).
  bit          m_outstanding;
  bit          m_handoff;
  logic [31:0] m_cnt;

  logic [5:0]  e_stall;
  logic        e_flush;
  logic [31:0] e_pc;
  logic        e_start;
  logic        e_annul;

  task automatic drive(input bit ifr, idr, exr, memr, dreq, drdy,
                       input logic [31:0] exc, epc);
    bus.stallreq_if_i    = ifr;
    bus.stallreq_id_i    = idr;
    bus.stallreq_ex_i    = exr;
    bus.stallreq_mem_i   = memr;
    bus.div_req_i        = dreq;
    bus.div_ready_i      = drdy;
    bus.exception_type_i = exc;
    bus.cp0_epc_i        = epc;
  endtask

  task automatic model_eval();
    int  deepest;
    bit  ex_hold;
    bit  quiet;
    quiet   = !m_outstanding && !m_handoff;
    e_flush = (bus.exception_type_i != 0);
    ex_hold = bus.stallreq_ex_i || m_outstanding || (quiet && bus.div_req_i);
    deepest = 0;
    if (bus.stallreq_if_i)  deepest = 1;
    if (bus.stallreq_id_i)  deepest = 2;
    if (ex_hold)            deepest = 3;
    if (bus.stallreq_mem_i) deepest = 4;
    e_stall = (deepest == 0 || e_flush) ? 6'd0 : 6'((1 << (deepest + 1)) - 1);
    e_pc    = !e_flush ? 32'd0 :
              (bus.exception_type_i == 32'he) ? bus.cp0_epc_i : 32'h40;
    e_start = quiet && bus.div_req_i && !e_flush;
    e_annul = e_flush && m_outstanding && !rst;
  endtask

  task automatic model_advance();
    if (rst) begin
      m_outstanding = 0;
      m_handoff     = 0;
      m_cnt         = 0;
    end else begin
      if (e_stall != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (e_flush) begin
        m_outstanding = 0;
        m_handoff     = 0;
      end else if (m_outstanding) begin
        if (bus.div_ready_i) begin
          m_outstanding = 0;
          m_handoff     = 1;
        end
      end else if (m_handoff) begin
        m_handoff = 0;
      end else if (e_start) begin
        m_outstanding = 1;
      end
    end
  endtask

  // Inputs are set right after a falling edge; check, then cross one edge.
  task automatic step();
    #1;
    model_eval();
    if (!rst) begin
      check_val("stall",  32'(bus.stall_o),     32'(e_stall));
      check_val("flush",  32'(bus.flush_o),     32'(e_flush));
      check_val("new_pc", bus.new_pc_o,         e_pc);
      check_val("start",  32'(bus.div_start_o), 32'(e_start));
      check_val("annul",  32'(bus.div_annul_o), 32'(e_annul));
      check_val("count",  bus.stall_cycles_o,   m_cnt);
    end
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    m_outstanding = 0;
    m_handoff     = 0;
    m_cnt         = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    step();
    step();
    rst = 1'b0;

    // Reset while a divide is in flight, with every request and an exception.
    drive(0, 0, 0, 0, 1, 0, 32'd0, 32'd0);
    step();
    rst = 1'b1;
    drive(1, 1, 1, 1, 1, 1, 32'h8, 32'd0);
    #1 check_val("rst_no_annul", 32'(bus.div_annul_o), 32'd0);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    #1;
    check_val("rst_cnt",   bus.stall_cycles_o, 32'd0);
    check_val("rst_stall", 32'(bus.stall_o),   32'd0);
    check_val("rst_start", 32'(bus.div_start_o), 32'd0);
    step();

    // Priority by depth.
    drive(1, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    #1 check_val("prio_if", 32'(bus.stall_o), 32'h03);
    step();
    drive(1, 1, 0, 0, 0, 0, 32'd0, 32'd0);
    #1 check_val("prio_id", 32'(bus.stall_o), 32'h07);
    step();
    drive(1, 1, 0, 1, 0, 0, 32'd0, 32'd0);
    #1 check_val("prio_mem", 32'(bus.stall_o), 32'h1F);
    step();
    drive(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    #1 check_val("prio_cnt", bus.stall_cycles_o, 32'd3);
    step();

    // Divide: request from cycle 10, result at cycle 45, release at 46.
    for (int k = 10; k <= 46; k++) begin
      drive(0, 0, 0, 0, 1, (k == 45), 32'd0, 32'd0);
      #1;
      check_val($sformatf("div_start_%0d", k), 32'(bus.div_start_o), 32'(k == 10));
      check_val($sformatf("div_stall_%0d", k), 32'(bus.stall_o), (k <= 45) ? 32'h0F : 32'h00);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    step();

    // Exception while MEM stalls.
    drive(0, 0, 0, 1, 0, 0, 32'h8, 32'h1234_5678);
    #1;
    check_val("exc_flush", 32'(bus.flush_o), 32'd1);
    check_val("exc_stall", 32'(bus.stall_o), 32'd0);
    check_val("exc_pc",    bus.new_pc_o,     32'h40);
    step();

    // ERET redirects to EPC.
    drive(0, 0, 0, 0, 0, 0, 32'he, 32'hBFC0_0100);
    #1 check_val("eret_pc", bus.new_pc_o, 32'hBFC0_0100);
    step();

    // Flush coincident with div_ready while busy, then an immediate new divide.
    drive(0, 0, 0, 0, 1, 0, 32'd0, 32'd0);
    step();
    step();
    drive(0, 0, 0, 0, 1, 1, 32'h8, 32'd0);
    #1;
    check_val("fdiv_annul", 32'(bus.div_annul_o), 32'd1);
    check_val("fdiv_start", 32'(bus.div_start_o), 32'd0);
    step();
    drive(0, 0, 0, 0, 1, 0, 32'd0, 32'd0);
    #1;
    check_val("fdiv_restart", 32'(bus.div_start_o), 32'd1);
    check_val("fdiv_annul2",  32'(bus.div_annul_o), 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 1, 32'd0, 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    step();

    // Counter saturation.
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    drive(1, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    step();
    step();
    step();
    drive(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    #1 check_val("sat_cnt", bus.stall_cycles_o, 32'hFFFF_FFFF);
    step();

    // Randomized traffic.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] exc;
      exc = 32'd0;
      if ($urandom_range(11) == 0)
        exc = ($urandom_range(1) == 0) ? 32'he : 32'($urandom_range(31, 1));
      rst = ($urandom_range(199) == 0);
      drive($urandom_range(3) == 0, $urandom_range(5) == 0, $urandom_range(7) == 0,
            $urandom_range(7) == 0, $urandom_range(2) == 0, $urandom_range(5) == 0,
            exc, $urandom);
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
